// File: rtl/trigger_ctrl.sv
// trigger_ctrl: single address-match debug trigger.
// Compares instruction-fetch and load/store addresses against tdata2 under
// the control of tdata1. On a hit it raises either a breakpoint-exception
// request or a debug-halt request and holds it until the matching ack.
module trigger_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  TRIG_TYPE  = 4'd2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [DATA_WIDTH-1:0] tdata1,
  input  logic [DATA_WIDTH-1:0] tdata2,
  input  logic                  dbg_mode,
  input  logic                  if_pc_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  ls_valid,
  input  logic                  ls_wr1_rd0,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic                  bp_exc_ack,
  input  logic                  dbg_halt_ack,
  output logic                  trig_hit_set,
  output logic                  bp_exc_req,
  output logic [DATA_WIDTH-1:0] bp_exc_addr,
  output logic                  dbg_halt_req
);

  // Match-mode and action encodings carried in tdata1.
  localparam logic [3:0] MATCH_EQ = 4'd0;
  localparam logic [3:0] MATCH_GE = 4'd2;
  localparam logic [3:0] MATCH_LT = 4'd3;
  localparam logic [3:0] ACT_EXC  = 4'd0;
  localparam logic [3:0] ACT_HALT = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Unsigned address compare; unsupported match encodings never fire.
  function automatic logic addr_match(input logic [3:0]            mode,
                                      input logic [DATA_WIDTH-1:0] addr,
                                      input logic [DATA_WIDTH-1:0] cmp);
    logic m;
    case (mode)
      MATCH_EQ: m = (addr == cmp);
      MATCH_GE: m = (addr >= cmp);
      MATCH_LT: m = (addr <  cmp);
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

  // tdata1 field decode.
  logic [3:0] cfg_type;
  logic [3:0] cfg_action;
  logic [3:0] cfg_match;
  logic       cfg_m;
  logic       cfg_exec;
  logic       cfg_store;
  logic       cfg_load;

  assign cfg_type   = tdata1[31:28];
  assign cfg_action = tdata1[15:12];
  assign cfg_match  = tdata1[10:7];
  assign cfg_m      = tdata1[6];
  assign cfg_exec   = tdata1[2];
  assign cfg_store  = tdata1[1];
  assign cfg_load   = tdata1[0];

  // Reserved / unimplemented tdata1 bits are intentionally ignored.
  logic unused_tdata1_bits;
  assign unused_tdata1_bits = ^{tdata1[27:16], tdata1[11], tdata1[5:3]};

  state_t                  state_q, state_d;
  logic                    hit_set_q, hit_set_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;

  logic                    armed;
  logic                    exec_hit;
  logic                    load_hit;
  logic                    store_hit;
  logic                    any_hit;
  logic                    take_exc;
  logic                    take_halt;
  logic [DATA_WIDTH-1:0]   hit_addr;

  // Combinational hit detection; execute takes priority for the reported address.
  always_comb begin
    armed     = (cfg_type == TRIG_TYPE) && cfg_m && !dbg_mode && (state_q == ST_IDLE);
    exec_hit  = if_pc_valid && cfg_exec && addr_match(cfg_match, if_pc, tdata2);
    load_hit  = ls_valid && !ls_wr1_rd0 && cfg_load  && addr_match(cfg_match, ls_addr, tdata2);
    store_hit = ls_valid &&  ls_wr1_rd0 && cfg_store && addr_match(cfg_match, ls_addr, tdata2);
    any_hit   = armed && (exec_hit || load_hit || store_hit);
    take_exc  = any_hit && (cfg_action == ACT_EXC);
    take_halt = any_hit && (cfg_action == ACT_HALT);
    hit_addr  = exec_hit ? if_pc : ls_addr;
  end

  // State, hit pulse and captured address registers.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q   <= ST_IDLE;
      hit_set_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      hit_set_q <= hit_set_d;
      addr_q    <= addr_d;
    end
  end

  // Next-state logic: accept a hit only in IDLE, leave a request state on its ack.
  always_comb begin
    state_d   = state_q;
    hit_set_d = 1'b0;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          state_d   = ST_EXC;
          hit_set_d = 1'b1;
          addr_d    = hit_addr;
        end else if (take_halt) begin
          state_d   = ST_HALT;
          hit_set_d = 1'b1;
          addr_d    = hit_addr;
        end
      end
      ST_EXC: begin
        if (bp_exc_ack) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (dbg_halt_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they are glitch-free and
  // mutually exclusive.
  always_comb begin
    trig_hit_set = hit_set_q;
    bp_exc_req   = (state_q == ST_EXC);
    dbg_halt_req = (state_q == ST_HALT);
    bp_exc_addr  = addr_q;
  end

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb_trigger_ctrl: directed scenarios plus randomized traffic, checked
// against a request/acknowledge reference model of the trigger.
module tb_trigger_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] tdata1 = '0;
  logic [31:0] tdata2 = '0;
  logic        dbg_mode = 1'b0;
  logic        if_pc_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        ls_valid = 1'b0;
  logic        ls_wr1_rd0 = 1'b0;
  logic [31:0] ls_addr = '0;
  logic        bp_exc_ack = 1'b0;
  logic        dbg_halt_ack = 1'b0;
  logic        trig_hit_set;
  logic        bp_exc_req;
  logic [31:0] bp_exc_addr;
  logic        dbg_halt_req;

  trigger_ctrl dut (
    .cpu_clk      (cpu_clk),
    .cpu_rstn     (cpu_rstn),
    .tdata1       (tdata1),
    .tdata2       (tdata2),
    .dbg_mode     (dbg_mode),
    .if_pc_valid  (if_pc_valid),
    .if_pc        (if_pc),
    .ls_valid     (ls_valid),
    .ls_wr1_rd0   (ls_wr1_rd0),
    .ls_addr      (ls_addr),
    .bp_exc_ack   (bp_exc_ack),
    .dbg_halt_ack (dbg_halt_ack),
    .trig_hit_set (trig_hit_set),
    .bp_exc_req   (bp_exc_req),
    .bp_exc_addr  (bp_exc_addr),
    .dbg_halt_req (dbg_halt_req)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: which request (if any) is outstanding, its address,
  // and whether a hit was accepted on the last edge.
  typedef enum int {PEND_NONE, PEND_EXC, PEND_HALT} pend_t;
  pend_t       m_pend  = PEND_NONE;
  logic [31:0] m_addr  = '0;
  logic        m_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit cmp_rule(input int mt, input logic [31:0] a, input logic [31:0] b);
    if (mt == 0) return a == b;
    if (mt == 2) return a >= b;
    if (mt == 3) return a < b;
    return 1'b0;
  endfunction

  // Apply the trigger rules to the inputs present just before a clock edge.
  task automatic model_edge();
    bit ex, ld, st, enabled;
    int mt, act;
    m_pulse = 1'b0;
    if (m_pend == PEND_NONE) begin
      mt  = int'(tdata1[10:7]);
      act = int'(tdata1[15:12]);
      enabled = (tdata1[31:28] == 4'd2) && tdata1[6] && !dbg_mode;
      ex = if_pc_valid && tdata1[2] && cmp_rule(mt, if_pc, tdata2);
      ld = ls_valid && !ls_wr1_rd0 && tdata1[0] && cmp_rule(mt, ls_addr, tdata2);
      st = ls_valid && ls_wr1_rd0 && tdata1[1] && cmp_rule(mt, ls_addr, tdata2);
      if (enabled && (ex || ld || st) && (act == 0 || act == 1)) begin
        m_pend  = (act == 0) ? PEND_EXC : PEND_HALT;
        m_addr  = ex ? if_pc : ls_addr;
        m_pulse = 1'b1;
      end
    end else if (m_pend == PEND_EXC && bp_exc_ack) begin
      m_pend = PEND_NONE;
    end else if (m_pend == PEND_HALT && dbg_halt_ack) begin
      m_pend = PEND_NONE;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pulse"}, 32'(trig_hit_set), 32'(m_pulse));
    check({tag, ".exc"},   32'(bp_exc_req),   32'(m_pend == PEND_EXC));
    check({tag, ".halt"},  32'(dbg_halt_req), 32'(m_pend == PEND_HALT));
    check({tag, ".addr"},  bp_exc_addr,       m_addr);
    check({tag, ".one"},   32'(bp_exc_req & dbg_halt_req), 32'd0);
  endtask

  // One clock: model the edge, let the DUT take it, compare 1ns later.
  task automatic step(input string tag);
    model_edge();
    @(posedge cpu_clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic quiet();
    if_pc_valid  = 1'b0;
    ls_valid     = 1'b0;
    bp_exc_ack   = 1'b0;
    dbg_halt_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pulse"}, 32'(trig_hit_set), 32'd0);
    check({tag, ".exc"},   32'(bp_exc_req),   32'd0);
    check({tag, ".halt"},  32'(dbg_halt_req), 32'd0);
    check({tag, ".addr"},  bp_exc_addr,       32'd0);
  endtask

  function automatic logic [31:0] pick_addr(input logic [31:0] ref_a);
    case ($urandom_range(0, 4))
      0: return ref_a;
      1: return ref_a + 32'd1;
      2: return ref_a - 32'd1;
      3: return ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset held: every output must read zero.
    #12;
    check_all_zero("rst_hold");
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // Execute hit on the very first edge after reset release.
    tdata1 = 32'h2000_0044; tdata2 = 32'h100;
    if_pc = 32'h100; if_pc_valid = 1'b1;
    step("exec_hit");
    check("exec_hit.addr_const", bp_exc_addr, 32'h100);
    check("exec_hit.req_const", 32'(bp_exc_req), 32'd1);
    quiet();
    step("exec_wait1");
    step("exec_wait2");
    bp_exc_ack = 1'b1;
    step("exec_ack");
    check("exec_ack.req_low", 32'(bp_exc_req), 32'd0);
    quiet();
    step("exec_idle");

    // Load hit with the enter-debug action.
    tdata1 = 32'h2000_1041; tdata2 = 32'h2000;
    ls_addr = 32'h2000; ls_valid = 1'b1; ls_wr1_rd0 = 1'b0;
    step("halt_hit");
    check("halt_hit.req_const", 32'(dbg_halt_req), 32'd1);
    quiet();
    bp_exc_ack = 1'b1;          // wrong ack must not release a halt
    step("halt_wrong_ack");
    bp_exc_ack = 1'b0;
    step("halt_wait");
    dbg_halt_ack = 1'b1;
    step("halt_ack");
    quiet();
    dbg_mode = 1'b1; ls_valid = 1'b1;
    step("dbg_mode_block");
    check("dbg_mode_block.pulse_const", 32'(trig_hit_set), 32'd0);
    quiet(); dbg_mode = 1'b0;
    step("dbg_mode_idle");

    // Greater-or-equal compare around the boundary; ack in the first request cycle.
    tdata1 = 32'h2000_0141; tdata2 = 32'h8000;
    ls_valid = 1'b1; ls_wr1_rd0 = 1'b0; ls_addr = 32'h7FFC;
    step("ge_below");
    ls_addr = 32'h8000;
    step("ge_equal");
    quiet(); bp_exc_ack = 1'b1;
    step("ge_fast_ack");
    quiet();

    // Less-than against zero never fires; against all-ones it does.
    tdata1 = 32'h2000_01C1; tdata2 = 32'h0; ls_valid = 1'b1;
    foreach (tdata2[i]) if (i < 3) begin
      ls_addr = (i == 0) ? 32'h0 : (i == 1) ? 32'hFFFF_FFFF : 32'h1234_5678;
      step("lt_zero");
    end
    tdata2 = 32'hFFFF_FFFF; ls_addr = 32'hFFFF_FFFE;
    step("lt_max");
    check("lt_max.addr_const", bp_exc_addr, 32'hFFFF_FFFE);
    quiet(); bp_exc_ack = 1'b1;
    step("lt_max_ack");
    quiet();

    // Simultaneous execute/load hit, then hits and config changes while busy.
    tdata1 = 32'h2000_0047; tdata2 = 32'h40;
    if_pc = 32'h40; if_pc_valid = 1'b1;
    ls_addr = 32'h40; ls_valid = 1'b1; ls_wr1_rd0 = 1'b0;
    step("simul_hit");
    check("simul_hit.addr_const", bp_exc_addr, 32'h40);
    step("simul_again");
    check("simul_again.pulse_const", 32'(trig_hit_set), 32'd0);
    tdata2 = 32'h0; if_pc = 32'h0; tdata1 = 32'h2000_0147;
    step("simul_cfg_change");
    dbg_mode = 1'b1;
    step("simul_dbg_rise");
    dbg_mode = 1'b0; quiet(); bp_exc_ack = 1'b1;
    step("simul_ack");
    quiet();
    // Execute wins address even when load address differs.
    tdata1 = 32'h2000_0147; tdata2 = 32'h10;
    if_pc = 32'h50; if_pc_valid = 1'b1;
    ls_addr = 32'h90; ls_valid = 1'b1; ls_wr1_rd0 = 1'b1;
    step("prio_hit");
    check("prio_hit.addr_const", bp_exc_addr, 32'h50);
    quiet();

    // Asynchronous reset in the middle of a handshake.
    step("pre_rst");
    cpu_rstn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    m_pend = PEND_NONE; m_addr = '0; m_pulse = 1'b0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [3:0] ty, act, mt;
        int r;
        ty  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd2;
        r   = $urandom_range(0, 9);
        act = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom);
        r   = $urandom_range(0, 7);
        mt  = (r < 3) ? 4'd0 : (r < 5) ? 4'd2 : (r < 7) ? 4'd3 : 4'($urandom);
        tdata1 = {ty, 12'($urandom), act, 1'($urandom), mt,
                  1'($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom)};
        tdata2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000;
      end
      dbg_mode     = ($urandom_range(0, 5) == 0);
      if_pc_valid  = ($urandom_range(0, 2) == 0);
      if_pc        = pick_addr(tdata2);
      ls_valid     = ($urandom_range(0, 2) == 0);
      ls_wr1_rd0   = 1'($urandom);
      ls_addr      = pick_addr(tdata2);
      bp_exc_ack   = ($urandom_range(0, 2) == 0);
      dbg_halt_ack = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
